// File: rtl/mips_mc_pkg.sv
// Shared encodings for the MIPS multi-cycle controller: states, opcodes, functs,
// ALUOp/ALUControl codes and the per-state control word.
package mips_mc_pkg;

    localparam int MC_STATE_W = 4;

    typedef enum logic [MC_STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_IDLE   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       instr_done;
    } ctrl_t;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_AND) ||
               (funct == FUNCT_OR)  || (funct == FUNCT_SLT);
    endfunction

    // Moore control word for a state; IDLE and unused codes yield all zeros.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
                c.alusrcb = 2'b01;
            end
            S_DECODE: c.alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.memtoreg   = 1'b1;
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c.iord       = 1'b1;
                c.memwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regdst     = 1'b1;
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                c.regwrite   = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca    = 1'b1;
                c.aluop      = ALUOP_SUB;
                c.pcsrc      = 2'b01;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JUMP: begin
                c.pcsrc      = 2'b10;
                c.pcwrite    = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> datapath bundle: IR fields and Zero in, enables/selects out.
interface mips_mc_controller_if;
    import mips_mc_pkg::*;

    logic [5:0]            Op;
    logic [5:0]            Funct;
    logic                  Zero;
    logic                  PCEn;
    logic                  IorD;
    logic                  MemWrite;
    logic                  IRWrite;
    logic                  RegDst;
    logic                  MemtoReg;
    logic                  RegWrite;
    logic                  ALUSrcA;
    logic [1:0]            ALUSrcB;
    logic [2:0]            ALUControl;
    logic [1:0]            PCSrc;
    logic                  instr_done;
    logic                  illegal;
    logic [MC_STATE_W-1:0] state;

    modport master (
        input  Op, Funct, Zero,
        output PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, instr_done, illegal, state
    );

    modport slave (
        output Op, Funct, Zero,
        input  PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, instr_done, illegal, state
    );

endinterface

// File: rtl/alu_decoder.sv
// ALU decoder: ALUOp + Funct -> ALUControl. Purely combinational so the
// single-cycle datapath can reuse it unchanged.
module alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        // NOTE: default first so every path assigns alu_control and no latch is inferred.
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default:   alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// MIPS multi-cycle main control FSM. The control word is registered alongside
// the state so every Moore output comes straight from a flop.
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mips_mc_controller_if.master bus
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [2:0] alu_ctrl;
    logic       op_legal;
    logic       illegal;

    always_comb begin
        state_d  = state_q;
        op_legal = 1'b1;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE: begin
                        op_legal = funct_legal(bus.Funct);
                        state_d  = op_legal ? S_EXEC : S_FETCH;
                    end
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_ADDI: state_d = S_ADDIEX;
                    OP_J:    state_d = S_JUMP;
                    default: begin
                        op_legal = 1'b0;
                        state_d  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: state_d = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
        ctrl_d  = state_ctrl(state_d);
        illegal = (state_q == S_DECODE) && !op_legal;
    end

    // Async reset clears the control word too, so an abandoned sw/lw can't
    // leave MemWrite or RegWrite high after rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments for all flops so every register samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    alu_decoder u_alu_dec (
        .alu_op      (ctrl_q.aluop),
        .funct       (bus.Funct),
        .alu_control (alu_ctrl)
    );

    assign bus.PCEn       = ctrl_q.pcwrite | (ctrl_q.branch & bus.Zero);
    assign bus.IorD       = ctrl_q.iord;
    assign bus.MemWrite   = ctrl_q.memwrite;
    assign bus.IRWrite    = ctrl_q.irwrite;
    assign bus.RegDst     = ctrl_q.regdst;
    assign bus.MemtoReg   = ctrl_q.memtoreg;
    assign bus.RegWrite   = ctrl_q.regwrite;
    assign bus.ALUSrcA    = ctrl_q.alusrca;
    assign bus.ALUSrcB    = ctrl_q.alusrcb;
    // IDLE is fully quiet, including the ALU code that ALUOp=00 would otherwise give.
    assign bus.ALUControl = (state_q == S_IDLE) ? 3'b000 : alu_ctrl;
    assign bus.PCSrc      = ctrl_q.pcsrc;
    assign bus.instr_done = ctrl_q.instr_done;
    assign bus.illegal    = illegal;
    assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: walks each instruction class state by
// state and compares the full output vector against hand-derived values.
module tb_mips_mc_controller;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mips_mc_controller_if bus ();

    mips_mc_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Vector order: state, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
    // RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, instr_done, illegal.
    task automatic expect_outs(input string tag, input logic [3:0] st,
                               input logic pcen, iord, memw, irw, regdst, m2r, regw, srca,
                               input logic [1:0] srcb, input logic [2:0] aluc,
                               input logic [1:0] pcsrc, input logic done, ill);
        logic [20:0] e;
        logic [20:0] o;
        e = {st, pcen, iord, memw, irw, regdst, m2r, regw, srca, srcb, aluc, pcsrc, done, ill};
        o = {bus.state, bus.PCEn, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst,
             bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
             bus.PCSrc, bus.instr_done, bus.illegal};
        check(tag, o, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_fetch(input string tag);
        expect_outs(tag, 4'd0, 1,0,0,1,0,0,0,0, 2'b01, 3'b010, 2'b00, 0, 0);
    endtask

    task automatic exp_decode(input string tag, input logic ill);
        expect_outs(tag, 4'd1, 0,0,0,0,0,0,0,0, 2'b11, 3'b010, 2'b00, 0, ill);
    endtask

    task automatic exp_idle(input string tag);
        expect_outs(tag, 4'd15, 0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0, 0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.Op    = 6'b000000;
        bus.Funct = 6'b100000;
        bus.Zero  = 1'b0;

        // Reset held for three edges, then released.
        repeat (3) @(posedge clk);
        #1;
        exp_idle("reset_low");
        rst_n = 1'b1;
        step();
        exp_fetch("reset_release_fetch");

        // lw: 0,1,2,3,4
        bus.Op    = 6'b100011;
        bus.Funct = 6'b100010;
        step(); exp_decode("lw_decode", 0);
        step(); expect_outs("lw_memadr", 4'd2, 0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0);
        step(); expect_outs("lw_memrd",  4'd3, 0,1,0,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 0, 0);
        step(); expect_outs("lw_memwb",  4'd4, 0,0,0,0,0,1,1,0, 2'b00, 3'b010, 2'b00, 1, 0);
        step(); exp_fetch("lw_back_fetch");

        // R-type sub: 0,1,6,7
        bus.Op    = 6'b000000;
        bus.Funct = 6'b100010;
        step(); exp_decode("sub_decode", 0);
        step(); expect_outs("sub_exec",  4'd6, 0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b00, 0, 0);
        step(); expect_outs("sub_aluwb", 4'd7, 0,0,0,0,1,0,1,0, 2'b00, 3'b010, 2'b00, 1, 0);
        step(); exp_fetch("sub_back_fetch");

        // R-type slt exercises another funct decode in EXEC
        bus.Funct = 6'b101010;
        step(); exp_decode("slt_decode", 0);
        step(); expect_outs("slt_exec",  4'd6, 0,0,0,0,0,0,0,1, 2'b00, 3'b111, 2'b00, 0, 0);
        step(); expect_outs("slt_aluwb", 4'd7, 0,0,0,0,1,0,1,0, 2'b00, 3'b010, 2'b00, 1, 0);
        step(); exp_fetch("slt_back_fetch");

        // beq taken (Zero=1), then Zero dropped mid-state to see PCEn follow it
        bus.Op   = 6'b000100;
        bus.Zero = 1'b1;
        step(); exp_decode("beq1_decode", 0);
        step(); expect_outs("beq1_branch", 4'd8, 1,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 1, 0);
        bus.Zero = 1'b0;
        #1;
        expect_outs("beq1_zero_drop", 4'd8, 0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 1, 0);
        step(); exp_fetch("beq1_back_fetch");

        // beq not taken (Zero=0)
        step(); exp_decode("beq0_decode", 0);
        step(); expect_outs("beq0_branch", 4'd8, 0,0,0,0,0,0,0,1, 2'b00, 3'b110, 2'b01, 1, 0);
        step(); exp_fetch("beq0_back_fetch");

        // addi: 0,1,9,10
        bus.Op = 6'b001000;
        step(); exp_decode("addi_decode", 0);
        step(); expect_outs("addi_ex", 4'd9,  0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0);
        step(); expect_outs("addi_wb", 4'd10, 0,0,0,0,0,0,1,0, 2'b00, 3'b010, 2'b00, 1, 0);
        step(); exp_fetch("addi_back_fetch");

        // j: 0,1,11
        bus.Op = 6'b000010;
        step(); exp_decode("j_decode", 0);
        step(); expect_outs("j_jump", 4'd11, 1,0,0,0,0,0,0,0, 2'b00, 3'b010, 2'b10, 1, 0);
        step(); exp_fetch("j_back_fetch");

        // sw complete: 0,1,2,5
        bus.Op = 6'b101011;
        step(); exp_decode("sw_decode", 0);
        step(); expect_outs("sw_memadr", 4'd2, 0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0);
        step(); expect_outs("sw_memwr",  4'd5, 0,1,1,0,0,0,0,0, 2'b00, 3'b010, 2'b00, 1, 0);
        step(); exp_fetch("sw_back_fetch");

        // Illegal opcode: illegal pulse in DECODE, straight back to FETCH
        bus.Op = 6'b111111;
        step(); exp_decode("badop_decode", 1);
        step(); exp_fetch("badop_back_fetch");

        // Illegal R-type funct
        bus.Op    = 6'b000000;
        bus.Funct = 6'b000111;
        step(); exp_decode("badfunct_decode", 1);
        step(); exp_fetch("badfunct_back_fetch");

        // sw interrupted by reset while in MEMADR
        bus.Op    = 6'b101011;
        bus.Funct = 6'b100000;
        step(); exp_decode("swrst_decode", 0);
        step(); expect_outs("swrst_memadr", 4'd2, 0,0,0,0,0,0,0,1, 2'b10, 3'b010, 2'b00, 0, 0);
        #2;
        rst_n = 1'b0;
        #2;
        exp_idle("swrst_async_idle");
        step(); exp_idle("swrst_held_1");
        step(); exp_idle("swrst_held_2");
        rst_n = 1'b1;
        step(); exp_fetch("swrst_release_fetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
